// File: rtl/line_window_3x3_stream.sv
// Streaming zero-padded 3x3 window generator backed by a 4-row circular line buffer.
// Emits one window per centre pixel in raster order; one channel plane per frame, frames never overlap.
module line_window_3x3_stream #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [DATA_W-1:0]  s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [9*DATA_W-1:0]       m_window,
    output logic [$clog2(HEIGHT)-1:0] m_row,
    output logic [$clog2(WIDTH)-1:0]  m_col,
    output logic                      m_last
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int RX = RW + 2;
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [RW-1:0] in_r_reg;
    logic [CW-1:0] in_c_reg;
    logic [RW-1:0] out_r_reg;
    logic [CW-1:0] out_c_reg;
    logic          out_done_reg;

    logic [DATA_W-1:0] line_mem [4][WIDTH];

    logic                in_fire;
    logic                in_last;
    logic                out_fire;
    logic                frame_done;
    logic                written;
    logic                eligible;
    logic                load;
    logic                at_last_pos;
    logic                room;
    logic [RW-1:0]       tgt_r;
    logic [CW-1:0]       tgt_c;
    logic [9*DATA_W-1:0] win_next;

    assign in_fire     = s_valid && s_ready;
    assign in_last     = in_fire && (in_r_reg == ROW_MAX) && (in_c_reg == COL_MAX);
    assign out_fire    = m_valid && m_ready;
    assign frame_done  = (state_reg == DRAIN) && out_fire && m_last;
    assign at_last_pos = (out_r_reg == ROW_MAX) && (out_c_reg == COL_MAX);

    // The window is ready once its bottom-right in-frame neighbour has been written.
    assign tgt_r = (out_r_reg == ROW_MAX) ? ROW_MAX : out_r_reg + RW'(1);
    assign tgt_c = (out_c_reg == COL_MAX) ? COL_MAX : out_c_reg + CW'(1);
    assign written = (in_r_reg > tgt_r) || ((in_r_reg == tgt_r) && (in_c_reg > tgt_c));

    // In DRAIN every pixel is present; out_done stops the wrapped counter re-emitting (0,0).
    assign eligible = (state_reg == DRAIN) ? !out_done_reg : written;
    assign load     = eligible && (!m_valid || m_ready);

    // Keeping input within rows out_r+2 protects row out_r-1, which shares slot (out_r+3) mod 4.
    assign room    = (RX'(in_r_reg) < (RX'(out_r_reg) + RX'(3)));
    assign s_ready = rst && (state_reg != DRAIN) && room;

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam int DR = gi / 3 - 1;
        localparam int DC = gi % 3 - 1;

        logic          row_ok;
        logic          col_ok;
        logic          tap_ok;
        logic [1:0]    slot;
        logic [CW-1:0] col;

        assign row_ok = (DR < 0) ? (out_r_reg != '0) :
                        (DR > 0) ? (out_r_reg != ROW_MAX) : 1'b1;
        assign col_ok = (DC < 0) ? (out_c_reg != '0) :
                        (DC > 0) ? (out_c_reg != COL_MAX) : 1'b1;
        assign tap_ok = row_ok && col_ok;
        assign slot   = 2'(out_r_reg) + 2'(DR);
        assign col    = tap_ok ? (out_c_reg + CW'(DC)) : '0;

        assign win_next[gi*DATA_W +: DATA_W] = tap_ok ? line_mem[slot][col] : '0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            line_mem[2'(in_r_reg)][in_c_reg] <= s_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                // A 2-row frame can deliver its final pixel before any window loads.
                if (in_last) begin
                    state_next = DRAIN;
                end else if (load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_done) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= FILL;
            in_r_reg     <= '0;
            in_c_reg     <= '0;
            out_r_reg    <= '0;
            out_c_reg    <= '0;
            out_done_reg <= 1'b0;
            m_valid      <= 1'b0;
            m_window     <= '0;
            m_row        <= '0;
            m_col        <= '0;
            m_last       <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (frame_done) begin
                in_r_reg <= '0;
                in_c_reg <= '0;
            end else if (in_fire) begin
                if (in_c_reg == COL_MAX) begin
                    in_c_reg <= '0;
                    in_r_reg <= (in_r_reg == ROW_MAX) ? '0 : in_r_reg + RW'(1);
                end else begin
                    in_c_reg <= in_c_reg + CW'(1);
                end
            end

            if (frame_done) begin
                out_r_reg <= '0;
                out_c_reg <= '0;
            end else if (load) begin
                if (out_c_reg == COL_MAX) begin
                    out_c_reg <= '0;
                    out_r_reg <= (out_r_reg == ROW_MAX) ? '0 : out_r_reg + RW'(1);
                end else begin
                    out_c_reg <= out_c_reg + CW'(1);
                end
            end

            if (frame_done) begin
                out_done_reg <= 1'b0;
            end else if (load && at_last_pos) begin
                out_done_reg <= 1'b1;
            end

            if (load) begin
                m_valid  <= 1'b1;
                m_window <= win_next;
                m_row    <= out_r_reg;
                m_col    <= out_c_reg;
                m_last   <= at_last_pos;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/line_window_3x3_stream.md
Name: line_window_3x3_stream

Overview:
- Streaming 3x3 window generator between max-pool stage 1 (16x16 per channel, raster order) and conv2d layer 2.
- Accepts one pixel per handshake and buffers rows in a 4-row circular line buffer.
- Emits one zero-padded ("same") 3x3 window per output pixel position, W*H windows per frame, in raster order of window centre.
- Processes one channel plane per frame; channels are streamed back-to-back as successive frames.

Parameters:
- WIDTH, 16, frame width in pixels (>=2)
- HEIGHT, 16, frame height in pixels (>=2)
- DATA_W, 8, signed pixel width (fixed-point, passed through unmodified)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept pixel
- s_data  in  DATA_W  signed input pixel
- m_valid  out  1  window valid
- m_ready  in  1  consumer accepts window
- m_window  out  9*DATA_W  taps; tap k = row-major index (dr+1)*3+(dc+1), dr/dc in {-1,0,1}; tap 0 in LSBs, tap 8 in MSBs
- m_row  out  clog2(HEIGHT)  centre row of window
- m_col  out  clog2(WIDTH)  centre column of window
- m_last  out  1  high with final window (HEIGHT-1, WIDTH-1) of frame

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-low.
- Reset values: s_ready=0 while rst low; m_valid=0, m_window=0, m_row=0, m_col=0, m_last=0; in/out counters=0; state=FILL. Line buffer contents are not cleared.
- Handshakes:
  - Input transfer when s_valid&&s_ready.
  - Output transfer when m_valid&&m_ready.
  - m_valid, m_window, m_row, m_col and m_last are held stable while m_valid&&!m_ready.
- Counters:
  - Input position (in_r,in_c) advances per input transfer, raster order.
  - Output position (out_r,out_c) advances per output-register load.
- Line buffer: 4 rows x WIDTH x DATA_W; pixel (r,c) is written to slot r mod 4, column c.
- Window eligibility: centre (out_r,out_c) is eligible when the pixel at (min(out_r+1,HEIGHT-1), min(out_c+1,WIDTH-1)) has been written.
- Output register loads when it is eligible and (!m_valid || m_ready). Sustains one window per cycle when m_ready is held high.
- Padding: taps with row<0, row>HEIGHT-1, col<0 or col>WIDTH-1 are forced to 0. In-range taps come from the buffer.
- Latency: the enabling pixel is transferred in cycle t; m_valid is high in cycle t+2, provided the output register is free.
- Input flow control: s_ready=1 only when state!=DRAIN and in_r < out_r+3. This prevents overwriting row out_r-1.
- State machine:
  - FILL: accepting pixels, no window yet eligible. Go to RUN when the first window loads.
  - RUN: input and output concurrent. Go to DRAIN when pixel (HEIGHT-1,WIDTH-1) is transferred.
  - DRAIN: s_ready=0. Emit the remaining windows, which need no new input. Return to FILL, with all counters=0, on the output transfer with m_last=1.
- Next frame: input is blocked until the last window of the current frame is accepted. There is no overlap between frames.
- Simultaneous events: an input transfer and an output load in the same cycle are both honoured. Eligibility uses the write count from before that edge.
- Reset mid-frame: everything returns to reset values immediately. Any partial frame is discarded and the next pixel after reset is treated as (0,0). Stale buffer data is never output, because every in-range tap is written before use.
- Widths: pure data movement; there is no arithmetic on pixels and no sign change.

Test Plan:
- Ramp frame:
  - Stimulus: pixel(r,c)=(16r+c) mod 128, m_ready=1, s_valid=1 continuous.
  - Window (0,0) = taps {0,0,0,0,0,1,0,16,17}.
  - Window (5,5) = {68,69,70,84,85,86,100,101,102}.
  - First m_valid exactly 2 cycles after the pixel-17 transfer.
  - 256 windows total; m_last only on (15,15), whose taps = {110,111,0,126,127,0,0,0,0}.
- Output backpressure:
  - Stimulus: m_ready=0 for 40 cycles mid-frame.
  - m_window, m_row and m_col stay stable.
  - s_ready drops once in_r reaches out_r+3.
  - After m_ready=1 resumes, no window is lost or duplicated; all 256 windows match the golden model in order.
- Input bubbles: s_valid random 50% duty, m_ready random 70% -> window sequence identical to the ramp-frame golden.
- Back-to-back frames: two frames, second frame = first negated.
  - s_ready=0 during DRAIN.
  - The second frame's window (0,0) taps = {0,0,0,0,0,-1,0,-16,-17}.
  - The second frame carries no first-frame data in any tap.
- Reset mid-frame: assert rst at input pixel 100, then restart a full ramp frame. Outputs and s_ready drop asynchronously, and the restarted frame matches the golden with exactly 256 windows.
- Minimum size (WIDTH=HEIGHT=2): input {1,2,3,4} -> 4 windows; window (0,0) = {0,0,0,0,1,2,0,3,4}; m_last on (1,1).
